// File: rtl/imem_loader_if.sv
// Byte-link and instruction-memory write bus between the host, imem_loader and the memory.
// master: host side of the byte link and observer of the memory bus; slave: the loader.
interface imem_loader_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        mem_mode;
    logic [7:0]  mem_address;
    logic [31:0] mem_write_data;
    logic        mem_write_enable;

    modport master (
        output rx_data, rx_valid,
        input  rx_ready, mem_mode, mem_address, mem_write_data, mem_write_enable
    );

    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, mem_mode, mem_address, mem_write_data, mem_write_enable
    );
endinterface

// File: rtl/imem_loader.sv
// Loads a count-prefixed, MSB-first byte stream into the 256x32 instruction memory, then releases the CPU.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte (mismatch leaves the CPU held off).
module imem_loader #(
    parameter logic [7:0] BASE_ADDR = 8'd0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    imem_loader_if.slave      bus,
    output logic              cpu_run,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [8:0]        words_loaded
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned CNT_W  = 9;

    typedef enum logic [2:0] {
        S_IDLE, S_COUNT, S_BYTE, S_WRITE, S_DONE
`ifdef LOADER_CHECKSUM_EN
        , S_CHECK, S_ERR
`endif
    } state_e;

    state_e              state_q, state_d;
    logic [BYTE_W-1:0]   count_q, count_d;
    logic [1:0]          byte_idx_q, byte_idx_d;
    logic [WORD_W-1:0]   asm_q, asm_d;
    logic [CNT_W-1:0]    words_loaded_q, words_loaded_d;
    logic                rx_ready_q, rx_ready_d;
    logic                mem_mode_q, mem_mode_d;
    logic [BYTE_W-1:0]   mem_address_q, mem_address_d;
    logic [WORD_W-1:0]   mem_write_data_q, mem_write_data_d;
    logic                mem_write_enable_q, mem_write_enable_d;
    logic                cpu_run_q, cpu_run_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
`ifdef LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0]   csum_q, csum_d;
    logic                error_q, error_d;
`endif

    logic                fire;
    logic                last_word;
    logic [CNT_W-1:0]    target;

    // Next state and datapath; outputs are decoded from the next state so they register cleanly.
    always_comb begin
        state_d          = state_q;
        count_d          = count_q;
        byte_idx_d       = byte_idx_q;
        asm_d            = asm_q;
        words_loaded_d   = words_loaded_q;
        mem_address_d    = mem_address_q;
        mem_write_data_d = mem_write_data_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d           = csum_q;
`endif
        fire      = bus.rx_valid && rx_ready_q;
        // A count byte of zero stands for a full 256-word image.
        target    = {(count_q == 8'd0), count_q};
        last_word = (words_loaded_q + 9'd1) == target;

        case (state_q)
            S_IDLE, S_DONE
`ifdef LOADER_CHECKSUM_EN
            , S_ERR
`endif
            : begin
                if (start) begin
                    state_d        = S_COUNT;
                    words_loaded_d = '0;
`ifdef LOADER_CHECKSUM_EN
                    csum_d         = '0;
`endif
                end
            end
            S_COUNT: begin
                if (fire) begin
                    count_d    = bus.rx_data;
                    byte_idx_d = 2'd0;
`ifdef LOADER_CHECKSUM_EN
                    csum_d     = csum_q ^ bus.rx_data;
`endif
                    state_d    = S_BYTE;
                end
            end
            S_BYTE: begin
                if (fire) begin
                    asm_d      = {asm_q[WORD_W-BYTE_W-1:0], bus.rx_data};
                    byte_idx_d = byte_idx_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                    csum_d     = csum_q ^ bus.rx_data;
`endif
                    if (byte_idx_q == 2'd3) begin
                        state_d          = S_WRITE;
                        mem_address_d    = BASE_ADDR + words_loaded_q[BYTE_W-1:0];
                        mem_write_data_d = {asm_q[WORD_W-BYTE_W-1:0], bus.rx_data};
                    end
                end
            end
            S_WRITE: begin
                words_loaded_d = words_loaded_q + 9'd1;
`ifdef LOADER_CHECKSUM_EN
                state_d        = last_word ? S_CHECK : S_BYTE;
`else
                state_d        = last_word ? S_DONE : S_BYTE;
`endif
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (fire) state_d = (bus.rx_data == csum_q) ? S_DONE : S_ERR;
            end
`endif
            default: state_d = S_IDLE;
        endcase

        rx_ready_d         = 1'b0;
        busy_d             = 1'b0;
        mem_mode_d         = 1'b1;
        mem_write_enable_d = 1'b0;
        cpu_run_d          = 1'b0;
        done_d             = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        error_d            = 1'b0;
`endif
        case (state_d)
            S_COUNT, S_BYTE: begin
                rx_ready_d = 1'b1;
                busy_d     = 1'b1;
                mem_mode_d = 1'b0;
            end
            S_WRITE: begin
                busy_d             = 1'b1;
                mem_mode_d         = 1'b0;
                mem_write_enable_d = 1'b1;
            end
            S_DONE: begin
                cpu_run_d = 1'b1;
                done_d    = 1'b1;
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHECK: begin
                rx_ready_d = 1'b1;
                busy_d     = 1'b1;
                mem_mode_d = 1'b0;
            end
            S_ERR: error_d = 1'b1;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q            <= S_IDLE;
            count_q            <= '0;
            byte_idx_q         <= '0;
            asm_q              <= '0;
            words_loaded_q     <= '0;
            rx_ready_q         <= 1'b0;
            mem_mode_q         <= 1'b1;
            mem_address_q      <= '0;
            mem_write_data_q   <= '0;
            mem_write_enable_q <= 1'b0;
            cpu_run_q          <= 1'b0;
            busy_q             <= 1'b0;
            done_q             <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_q             <= '0;
            error_q            <= 1'b0;
`endif
        end else begin
            state_q            <= state_d;
            count_q            <= count_d;
            byte_idx_q         <= byte_idx_d;
            asm_q              <= asm_d;
            words_loaded_q     <= words_loaded_d;
            rx_ready_q         <= rx_ready_d;
            mem_mode_q         <= mem_mode_d;
            mem_address_q      <= mem_address_d;
            mem_write_data_q   <= mem_write_data_d;
            mem_write_enable_q <= mem_write_enable_d;
            cpu_run_q          <= cpu_run_d;
            busy_q             <= busy_d;
            done_q             <= done_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q             <= csum_d;
            error_q            <= error_d;
`endif
        end
    end

    assign bus.rx_ready         = rx_ready_q;
    assign bus.mem_mode         = mem_mode_q;
    assign bus.mem_address      = mem_address_q;
    assign bus.mem_write_data   = mem_write_data_q;
    assign bus.mem_write_enable = mem_write_enable_q;
    assign cpu_run              = cpu_run_q;
    assign busy                 = busy_q;
    assign done                 = done_q;
    assign words_loaded         = words_loaded_q;
`ifdef LOADER_CHECKSUM_EN
    assign error                = error_q;
`else
    assign error                = 1'b0;
`endif

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that drives the write side of the 256×32 instruction memory. It accepts a byte stream over a valid/ready handshake and assembles 32-bit instruction words MSB-first. It writes each word into instruction memory at consecutive addresses, then returns the memory to read mode and releases the CPU. It sits between the host byte link (UART receiver or testbench) and the instruction memory's mode/address/write_data/write_enable inputs.

## Interface
- BASE_ADDR, 8'd0, first instruction-memory address written.
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-high.
- start  input  1  single-cycle load request; sampled only in IDLE, DONE or ERR.
- rx_data  input  8  incoming byte.
- rx_valid  input  1  rx_data valid.
- rx_ready  output  1  loader can accept a byte this cycle.
- mem_mode  output  1  to memory mode: 0 = load/write, 1 = read/run.
- mem_address  output  8  memory address.
- mem_write_data  output  32  assembled instruction word.
- mem_write_enable  output  1  one-cycle write strobe.
- cpu_run  output  1  high = CPU may fetch; low holds CPU off.
- busy  output  1  load in progress.
- done  output  1  level; load completed successfully, held until next start.
- error  output  1  level; checksum mismatch, held until next start.
- words_loaded  output  9  count of words written in the current load, 0..256.

## Operation
- Frame format: count byte N (N=0 means 256 words), then 4·N data bytes, MSB first per word. Under LOADER_CHECKSUM_EN, one trailing checksum byte follows.
- A byte transfers on a rising edge when rx_valid && rx_ready. rx_data and rx_valid may change freely while rx_ready=0.
- States:
  - IDLE: rx_ready=0. start → COUNT.
  - COUNT: rx_ready=1. Byte accepted → store N, clear byte index and word index → BYTE.
  - BYTE: rx_ready=1. Accepted bytes shift into a 32-bit assembly register, first byte landing in [31:24]. On the 4th byte → WRITE.
  - WRITE: one cycle, rx_ready=0. mem_write_enable=1, mem_address=BASE_ADDR+word index (8-bit, wraps mod 256), mem_write_data=assembled word. words_loaded increments at the end of the cycle. If this is the last word → CHECK (checksum build) or DONE (no checksum build); otherwise → BYTE.
  - CHECK: rx_ready=1. Byte accepted → DONE if it equals the running checksum, else ERR.
  - DONE: mem_mode=1, cpu_run=1, done=1. start → COUNT.
  - ERR: mem_mode=1, cpu_run=0, error=1. start → COUNT.
- Accepting start: mem_mode←0, cpu_run←0, done←0, error←0, words_loaded←0, busy←1. busy is 1 in COUNT, BYTE, WRITE and CHECK.
- start in COUNT/BYTE/WRITE/CHECK is ignored. No abort path other than reset.
- mem_address and mem_write_data hold their last values outside WRITE. mem_write_enable is 0 outside WRITE.

## Timing
- Reset values: rx_ready=0, mem_mode=1, mem_address=0, mem_write_data=0, mem_write_enable=0, cpu_run=0, busy=0, done=0, error=0, words_loaded=0. State=IDLE, assembly register and checksum cleared.
- Reset mid-load: immediate return to reset values. Memory contents already written are kept and the partial load is abandoned.
- All outputs are registered.
- The 4th byte of a word is accepted on edge k. mem_write_enable is high in cycle k+1, and the memory captures the word on edge k+2. rx_ready is low for exactly that one cycle.
- Full rate: 5 cycles per word, continuous rx_valid. N words take 1 + 5N cycles after COUNT entry (+1 with checksum).
- mem_mode is 0 continuously from the cycle after start acceptance through the last WRITE cycle. It switches to 1 in the same cycle cpu_run/done rise, which is the cycle after the last WRITE, or after the checksum byte.
- N=0: 256 words, addresses BASE_ADDR..BASE_ADDR+255 with wrap; words_loaded ends at 256.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - Running 8-bit XOR over the count byte and all data bytes, cleared on start.
  - CHECK state present; mismatch → ERR with cpu_run held 0.
- Undefined:
  - No checksum logic and no CHECK state.
  - Last WRITE goes directly to DONE; error is tied to 0.

## Test plan
- Reset then idle: all outputs at reset values, mem_mode=1, cpu_run=0, rx_ready=0 for 20 cycles regardless of rx_valid.
- start, bytes 02, 30 00 00 00, 10 1F 08 00 at full rate, BASE_ADDR=0 → write strobes: addr 0 data 32'h30000000, then addr 1 data 32'h101F0800. Each strobe is exactly 1 cycle; done=1, cpu_run=1, mem_mode=1, words_loaded=2.
- Same frame with rx_valid toggling randomly → identical writes. No byte is lost or duplicated, and rx_ready=0 during each WRITE cycle.
- BASE_ADDR=8'hFE, N=3 → writes at FE, FF, 00 (wrap).
- N=0 with 1024 bytes → 256 writes, words_loaded=256, done=1.
- LOADER_CHECKSUM_EN, frame 01 AA BB CC DD plus checksum:
  - checksum 01^AA^BB^CC^DD = 8'h01 → done=1.
  - checksum 8'h00 → error=1, cpu_run=0, mem_mode=1. A following start clears error.
  - reset asserted during byte 3 → all outputs return to reset values immediately.
